// File: rtl/uart_host_bridge_pkg.sv
// rtl/uart_host_bridge_pkg.sv - register map, STATUS layout and status packing for uart_host_bridge
package uart_host_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  localparam int ST_RX_NOT_EMPTY = 0;
  localparam int ST_TX_FULL      = 1;
  localparam int ST_RX_OVERRUN   = 2;
  localparam int ST_TX_OVERFLOW  = 3;
  localparam int ST_TX_IDLE      = 4;
  localparam int ST_RX_COUNT_LSB = 8;
  localparam int ST_TX_COUNT_LSB = 16;

  localparam logic [31:0] EMPTY_READ = 32'hFFFF_FFFF;

  function automatic logic [31:0] pack_status(
    input logic       rx_not_empty,
    input logic       tx_full,
    input logic       rx_overrun,
    input logic       tx_overflow,
    input logic       tx_idle,
    input logic [7:0] rx_count,
    input logic [7:0] tx_count
  );
    logic [31:0] s;
    s = '0;
    s[ST_RX_NOT_EMPTY] = rx_not_empty;
    s[ST_TX_FULL]      = tx_full;
    s[ST_RX_OVERRUN]   = rx_overrun;
    s[ST_TX_OVERFLOW]  = tx_overflow;
    s[ST_TX_IDLE]      = tx_idle;
    s[ST_RX_COUNT_LSB +: 8] = rx_count;
    s[ST_TX_COUNT_LSB +: 8] = tx_count;
    return s;
  endfunction

endpackage

// File: rtl/uart_host_bridge_if.sv
// rtl/uart_host_bridge_if.sv - single-cycle-ack CPU register bus between host and uart_host_bridge
interface uart_host_bridge_if;
  logic        cpu_valid;
  logic        cpu_write;
  logic [1:0]  cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;

  modport master (
    output cpu_valid, cpu_write, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack
  );

  modport slave (
    input  cpu_valid, cpu_write, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack
  );
endinterface

// File: rtl/uart_host_bridge_byte_fifo.sv
// rtl/uart_host_bridge_byte_fifo.sv - byte_fifo: circular byte buffer with occupancy count
module byte_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          w_pop;
  logic          w_push;

  // A push into a full buffer is only legal when a real pop frees the slot in the same cycle.
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);

  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_host_bridge.sv
// rtl/uart_host_bridge.sv - CPU-side TX/RX byte FIFOs and register port for the UART engine.
// Optional UART_RX_IRQ_EN adds CTRL[0] irq_enable and the registered irq output.
module uart_host_bridge
  import uart_host_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  uart_host_bridge_if.slave   cpu,
  input  logic                rx_complete,
  input  logic [7:0]          rx_data,
  output logic                tx_valid,
  output logic [7:0]          tx_data,
  input  logic                tx_complete
`ifdef UART_RX_IRQ_EN
  , output logic              irq
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          w_rd;
  logic          w_wr;
  logic          w_tx_push;
  logic          w_tx_drop;
  logic          w_rx_pop;
  logic          w_rx_drop;
  logic          w_sts_wr;
  logic [7:0]    w_tx_head;
  logic          w_tx_full;
  logic          w_tx_empty;
  logic [CW-1:0] w_tx_count;
  logic [7:0]    w_rx_head;
  logic          w_rx_full;
  logic          w_rx_empty;
  logic [CW-1:0] w_rx_count;
  logic [31:0]   w_status;
  logic [31:0]   w_ctrl;
  logic [31:0]   w_rdata_nxt;

  logic          r_ack;
  logic [31:0]   r_rdata;
  logic          r_rx_overrun;
  logic          r_tx_overflow;

  assign w_rd      = cpu.cpu_valid & ~cpu.cpu_write;
  assign w_wr      = cpu.cpu_valid &  cpu.cpu_write;
  assign w_tx_push = w_wr & (cpu.cpu_addr == ADDR_DATA);
  assign w_rx_pop  = w_rd & (cpu.cpu_addr == ADDR_DATA) & ~w_rx_empty;
  assign w_sts_wr  = w_wr & (cpu.cpu_addr == ADDR_STATUS);

  // A full FIFO is never empty, so a coinciding tx_complete always frees a slot.
  assign w_tx_drop = w_tx_push & w_tx_full & ~tx_complete;
  assign w_rx_drop = rx_complete & w_rx_full & ~w_rx_pop;

  byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (w_tx_push),
    .push_data (cpu.cpu_wdata),
    .pop       (tx_complete),
    .head      (w_tx_head),
    .full      (w_tx_full),
    .empty     (w_tx_empty),
    .count     (w_tx_count)
  );

  byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (rx_complete),
    .push_data (rx_data),
    .pop       (w_rx_pop),
    .head      (w_rx_head),
    .full      (w_rx_full),
    .empty     (w_rx_empty),
    .count     (w_rx_count)
  );

  // The UART builds its frame from tx_data directly, so the head must stay put until tx_complete.
  assign tx_valid = ~w_tx_empty;
  assign tx_data  = w_tx_head;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_rx_overrun  <= 1'b0;
      r_tx_overflow <= 1'b0;
    end else begin
      if (w_rx_drop) begin
        r_rx_overrun <= 1'b1;
      end else if (w_sts_wr && cpu.cpu_wdata[ST_RX_OVERRUN]) begin
        r_rx_overrun <= 1'b0;
      end
      if (w_tx_drop) begin
        r_tx_overflow <= 1'b1;
      end else if (w_sts_wr && cpu.cpu_wdata[ST_TX_OVERFLOW]) begin
        r_tx_overflow <= 1'b0;
      end
    end
  end

  assign w_status = pack_status(~w_rx_empty, w_tx_full, r_rx_overrun, r_tx_overflow,
                                w_tx_empty, 8'(w_rx_count), 8'(w_tx_count));

`ifdef UART_RX_IRQ_EN
  logic r_ctrl_irq;
  logic r_irq;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_ctrl_irq <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      if (w_wr && (cpu.cpu_addr == ADDR_CTRL)) begin
        r_ctrl_irq <= cpu.cpu_wdata[0];
      end
      r_irq <= r_ctrl_irq & (~w_rx_empty | r_rx_overrun);
    end
  end

  assign w_ctrl = {31'b0, r_ctrl_irq};
  assign irq    = r_irq;
`else
  assign w_ctrl = '0;
`endif

  always_comb begin
    w_rdata_nxt = '0;
    if (w_rd) begin
      case (cpu.cpu_addr)
        ADDR_DATA:   w_rdata_nxt = w_rx_empty ? EMPTY_READ : {24'b0, w_rx_head};
        ADDR_STATUS: w_rdata_nxt = w_status;
        ADDR_CTRL:   w_rdata_nxt = w_ctrl;
        default:     w_rdata_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= cpu.cpu_valid;
      r_rdata <= w_rdata_nxt;
    end
  end

  assign cpu.cpu_ack   = r_ack;
  assign cpu.cpu_rdata = r_rdata;

endmodule

// File: tb/tb_uart_host_bridge.sv
// tb/tb_uart_host_bridge.sv - randomized, model-checked bench for uart_host_bridge
module tb_uart_host_bridge;
  import uart_host_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       rx_complete;
  logic [7:0] rx_data;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_complete;
`ifdef UART_RX_IRQ_EN
  logic       irq;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] m_rx_q[$];
  logic [7:0] m_tx_q[$];
  logic       m_rx_ovr;
  logic       m_tx_ovf;

  uart_host_bridge_if bus ();

  uart_host_bridge #(.DEPTH(16)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .cpu         (bus),
    .rx_complete (rx_complete),
    .rx_data     (rx_data),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_complete (tx_complete)
`ifdef UART_RX_IRQ_EN
    , .irq       (irq)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    int rc, tc;
    rc = m_rx_q.size();
    tc = m_tx_q.size();
    s = 32'h0;
    s[0] = (rc != 0);
    s[1] = (tc == 16);
    s[2] = m_rx_ovr;
    s[3] = m_tx_ovf;
    s[4] = (tc == 0);
    s[15:8]  = 8'(rc);
    s[23:16] = 8'(tc);
    return s;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    m_rx_q.delete();
    m_tx_q.delete();
    m_rx_ovr = 1'b0;
    m_tx_ovf = 1'b0;
  endtask

  task automatic cpu_xfer(input logic wr, input logic [1:0] a, input logic [7:0] d,
                          output logic [31:0] rd, output logic ack);
    @(negedge clock);
    bus.cpu_valid = 1'b1;
    bus.cpu_write = wr;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    @(negedge clock);
    bus.cpu_valid = 1'b0;
    bus.cpu_write = 1'b0;
    rd  = bus.cpu_rdata;
    ack = bus.cpu_ack;
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    @(negedge clock);
    rx_complete = 1'b1;
    rx_data     = d;
    @(negedge clock);
    rx_complete = 1'b0;
  endtask

  task automatic tx_pulse();
    @(negedge clock);
    tx_complete = 1'b1;
    @(negedge clock);
    tx_complete = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic ack;
    do_reset();
    n_cmp++;
    if (bus.cpu_ack !== 1'b0 || bus.cpu_rdata !== 32'h0 || tx_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: ack=%b rdata=%h tx_valid=%b, required 0/0/0",
               bus.cpu_ack, bus.cpu_rdata, tx_valid);
    end
    cpu_xfer(1'b0, ADDR_STATUS, 8'h0, rd, ack);
    n_cmp++;
    if (rd !== 32'h0000_0010 || ack !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_status: got %h ack=%b, required 00000010 ack=1", rd, ack);
    end
    @(negedge clock);
    n_cmp++;
    if (bus.cpu_ack !== 1'b0 || bus.cpu_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL ack_width: ack=%b rdata=%h one cycle later, required 0/0", bus.cpu_ack, bus.cpu_rdata);
    end
    cpu_xfer(1'b0, 2'd3, 8'h0, rd, ack);
    n_cmp++;
    if (rd !== 32'h0 || ack !== 1'b1) begin
      n_bad++;
      $display("FAIL addr3_read: got %h ack=%b, required 0 ack=1", rd, ack);
    end
    cpu_xfer(1'b0, ADDR_CTRL, 8'h0, rd, ack);
    n_cmp++;
    if (rd !== 32'h0 || ack !== 1'b1) begin
      n_bad++;
      $display("FAIL ctrl_reset_read: got %h ack=%b, required 0 ack=1", rd, ack);
    end
    cpu_xfer(1'b0, ADDR_DATA, 8'h0, rd, ack);
    n_cmp++;
    if (rd !== EMPTY_READ) begin
      n_bad++;
      $display("FAIL empty_data_read: got %h, required ffffffff", rd);
    end
  endtask

  task automatic test_tx_burst();
    logic [31:0] rd;
    logic ack;
    logic [7:0] exp;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cpu_xfer(1'b1, ADDR_DATA, 8'h41 + 8'(i), rd, ack);
      m_tx_q.push_back(8'h41 + 8'(i));
      n_cmp++;
      if (rd !== 32'h0 || ack !== 1'b1) begin
        n_bad++;
        $display("FAIL tx_write_ack: rdata=%h ack=%b, required 0 ack=1", rd, ack);
      end
    end
    for (int f = 0; f < 3; f++) begin
      exp = m_tx_q.pop_front();
      n_cmp++;
      if (tx_valid !== 1'b1 || tx_data !== exp) begin
        n_bad++;
        $display("FAIL tx_frame_start%0d: valid=%b data=%h, required 1/%h", f, tx_valid, tx_data, exp);
      end
      repeat (500) begin
        @(negedge clock);
        if (tx_data !== exp) break;
      end
      n_cmp++;
      if (tx_data !== exp) begin
        n_bad++;
        $display("FAIL tx_head_stable%0d: data=%h, required %h", f, tx_data, exp);
      end
      tx_pulse();
    end
    n_cmp++;
    if (tx_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL tx_drained: tx_valid=%b, required 0", tx_valid);
    end
    cpu_xfer(1'b0, ADDR_STATUS, 8'h0, rd, ack);
    n_cmp++;
    if (rd !== model_status()) begin
      n_bad++;
      $display("FAIL tx_idle_status: got %h, required %h", rd, model_status());
    end
  endtask

  task automatic test_rx_overrun();
    logic [31:0] rd;
    logic ack;
    do_reset();
    for (int i = 0; i < 17; i++) rx_pulse(8'(i));
    cpu_xfer(1'b0, ADDR_STATUS, 8'h0, rd, ack);
    n_cmp++;
    if (rd !== 32'h0000_1015) begin
      n_bad++;
      $display("FAIL rx_overrun_status: got %h, required 00001015", rd);
    end
    for (int i = 0; i < 17; i++) begin
      cpu_xfer(1'b0, ADDR_DATA, 8'h0, rd, ack);
      n_cmp++;
      if (rd !== ((i < 16) ? {24'h0, 8'(i)} : EMPTY_READ)) begin
        n_bad++;
        $display("FAIL rx_drain%0d: got %h, required %h", i, rd,
                 (i < 16) ? {24'h0, 8'(i)} : EMPTY_READ);
      end
    end
  endtask

  task automatic test_tx_full();
    logic [31:0] rd;
    logic ack;
    do_reset();
    for (int i = 0; i < 17; i++) cpu_xfer(1'b1, ADDR_DATA, 8'(8'h80 + i), rd, ack);
    cpu_xfer(1'b0, ADDR_STATUS, 8'h0, rd, ack);
    n_cmp++;
    if (rd !== 32'h0010_000A) begin
      n_bad++;
      $display("FAIL tx_full_status: got %h, required 0010000a", rd);
    end
    cpu_xfer(1'b1, ADDR_STATUS, 8'h08, rd, ack);
    cpu_xfer(1'b0, ADDR_STATUS, 8'h0, rd, ack);
    n_cmp++;
    if (rd !== 32'h0010_0002) begin
      n_bad++;
      $display("FAIL tx_ovf_w1c: got %h, required 00100002", rd);
    end
    n_cmp++;
    if (tx_data !== 8'h80) begin
      n_bad++;
      $display("FAIL tx_full_head: got %h, required 80", tx_data);
    end
  endtask

  task automatic test_simul_push_pop();
    logic [31:0] rd;
    logic ack;
    do_reset();
    for (int i = 0; i < 16; i++) rx_pulse(8'(i + 1));
    @(negedge clock);
    bus.cpu_valid = 1'b1;
    bus.cpu_write = 1'b0;
    bus.cpu_addr  = ADDR_DATA;
    rx_complete   = 1'b1;
    rx_data       = 8'hAA;
    @(negedge clock);
    bus.cpu_valid = 1'b0;
    rx_complete   = 1'b0;
    n_cmp++;
    if (bus.cpu_rdata !== 32'h01) begin
      n_bad++;
      $display("FAIL simul_read: got %h, required 00000001", bus.cpu_rdata);
    end
    cpu_xfer(1'b0, ADDR_STATUS, 8'h0, rd, ack);
    n_cmp++;
    if (rd !== 32'h0000_1011) begin
      n_bad++;
      $display("FAIL simul_status: got %h, required 00001011", rd);
    end
    for (int i = 0; i < 16; i++) begin
      cpu_xfer(1'b0, ADDR_DATA, 8'h0, rd, ack);
      n_cmp++;
      if (rd !== ((i < 15) ? {24'h0, 8'(i + 2)} : 32'hAA)) begin
        n_bad++;
        $display("FAIL simul_drain%0d: got %h, required %h", i, rd,
                 (i < 15) ? {24'h0, 8'(i + 2)} : 32'hAA);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] rd;
    logic ack;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cpu_xfer(1'b1, ADDR_DATA, 8'(8'h30 + i), rd, ack);
      rx_pulse(8'(8'h50 + i));
    end
    cpu_xfer(1'b1, ADDR_DATA, 8'h0, rd, ack);
    do_reset();
    n_cmp++;
    if (tx_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_tx_valid: got %b, required 0", tx_valid);
    end
    cpu_xfer(1'b0, ADDR_STATUS, 8'h0, rd, ack);
    n_cmp++;
    if (rd !== 32'h0000_0010) begin
      n_bad++;
      $display("FAIL midreset_status: got %h, required 00000010", rd);
    end
    cpu_xfer(1'b0, ADDR_DATA, 8'h0, rd, ack);
    n_cmp++;
    if (rd !== EMPTY_READ) begin
      n_bad++;
      $display("FAIL midreset_data: got %h, required ffffffff", rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, exp;
    logic ack;
    logic [7:0] d;
    int op;
    do_reset();
    for (int it = 0; it < 600; it++) begin
      op = int'($urandom_range(0, 9));
      d  = 8'($urandom);
      exp = 32'h0;
      case (op)
        0, 1, 2: begin
          cpu_xfer(1'b1, ADDR_DATA, d, rd, ack);
          if (m_tx_q.size() < 16) m_tx_q.push_back(d);
          else m_tx_ovf = 1'b1;
        end
        3, 4: begin
          exp = (m_rx_q.size() != 0) ? {24'h0, m_rx_q.pop_front()} : EMPTY_READ;
          cpu_xfer(1'b0, ADDR_DATA, 8'h0, rd, ack);
        end
        5: begin
          exp = model_status();
          cpu_xfer(1'b0, ADDR_STATUS, 8'h0, rd, ack);
        end
        6, 7: begin
          rx_pulse(d);
          if (m_rx_q.size() < 16) m_rx_q.push_back(d);
          else m_rx_ovr = 1'b1;
          rd = 32'h0;
          ack = 1'b1;
        end
        8: begin
          tx_pulse();
          if (m_tx_q.size() != 0) void'(m_tx_q.pop_front());
          rd = 32'h0;
          ack = 1'b1;
        end
        default: begin
          cpu_xfer(1'b1, ADDR_STATUS, d, rd, ack);
          if (d[2]) m_rx_ovr = 1'b0;
          if (d[3]) m_tx_ovf = 1'b0;
        end
      endcase
      n_cmp++;
      if (rd !== exp || ack !== 1'b1) begin
        n_bad++;
        $display("FAIL random_op%0d it%0d: rdata=%h ack=%b, required %h ack=1", op, it, rd, ack, exp);
      end
      n_cmp++;
      if (tx_valid !== (m_tx_q.size() != 0) || (tx_valid && tx_data !== m_tx_q[0])) begin
        n_bad++;
        $display("FAIL random_tx it%0d: valid=%b data=%h, required valid=%b", it, tx_valid, tx_data,
                 m_tx_q.size() != 0);
      end
    end
    cpu_xfer(1'b0, ADDR_STATUS, 8'h0, rd, ack);
    n_cmp++;
    if (rd !== model_status()) begin
      n_bad++;
      $display("FAIL random_final_status: got %h, required %h", rd, model_status());
    end
  endtask

`ifdef UART_RX_IRQ_EN
  task automatic test_irq();
    logic [31:0] rd;
    logic ack;
    do_reset();
    cpu_xfer(1'b1, ADDR_CTRL, 8'h01, rd, ack);
    cpu_xfer(1'b0, ADDR_CTRL, 8'h00, rd, ack);
    n_cmp++;
    if (rd !== 32'h1) begin
      n_bad++;
      $display("FAIL ctrl_readback: got %h, required 00000001", rd);
    end
    rx_pulse(8'h5A);
    @(negedge clock);
    n_cmp++;
    if (irq !== 1'b1) begin
      n_bad++;
      $display("FAIL irq_set: got %b, required 1", irq);
    end
    cpu_xfer(1'b0, ADDR_DATA, 8'h0, rd, ack);
    @(negedge clock);
    n_cmp++;
    if (irq !== 1'b0 || rd !== 32'h5A) begin
      n_bad++;
      $display("FAIL irq_clear: irq=%b data=%h, required 0/0000005a", irq, rd);
    end
  endtask
`endif

  initial begin
    reset_n       = 1'b0;
    rx_complete   = 1'b0;
    rx_data       = 8'h0;
    tx_complete   = 1'b0;
    bus.cpu_valid = 1'b0;
    bus.cpu_write = 1'b0;
    bus.cpu_addr  = 2'd0;
    bus.cpu_wdata = 8'h0;
    m_rx_ovr      = 1'b0;
    m_tx_ovf      = 1'b0;
    test_reset();
    test_tx_burst();
    test_rx_overrun();
    test_tx_full();
    test_simul_push_pop();
    test_reset_mid_op();
    test_random();
`ifdef UART_RX_IRQ_EN
    test_irq();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_host_bridge.md
Name: uart_host_bridge

Overview:
- CPU-side companion to the UART byte engine; the other end of its rx_complete/rx_data and tx_valid/tx_data/tx_complete byte interface.
- Buffers outgoing bytes in a TX FIFO and feeds them to the UART one at a time.
- Captures received bytes into an RX FIFO.
- Exposes both FIFOs plus status through a simple single-cycle-ack register port on the CPU peripheral bus.

Parameters:
- DEPTH, 16, entries per FIFO; power of two, minimum 2.
- CW, $clog2(DEPTH)+1, occupancy counter width (derived; not overridden).

Ports:
- clock  in  1  system clock, 100 MHz
- reset_n  in  1  synchronous reset, active-low
- cpu_valid  in  1  bus request strobe, one cycle per access
- cpu_write  in  1  1 = write, 0 = read
- cpu_addr  in  2  register select: 0 DATA, 1 STATUS, 2 CTRL
- cpu_wdata  in  8  write data
- cpu_rdata  out  32  read data, valid when cpu_ack=1
- cpu_ack  out  1  access acknowledge
- rx_complete  in  1  one-cycle pulse from UART: byte received
- rx_data  in  8  received byte, valid with rx_complete
- tx_valid  out  1  byte available for the UART
- tx_data  out  8  byte to transmit
- tx_complete  in  1  one-cycle pulse from UART: byte shifted out (start of stop bit)

Behaviour:
- Reset (clock edge with reset_n=0): both FIFOs empty, pointers and counts 0, sticky flags 0, CTRL 0. Outputs at reset: cpu_ack=0, cpu_rdata=0, tx_valid=0.
- Reset mid-transfer: queued TX bytes are discarded. The byte already latched by the UART is not aborted. tx_data drops to the FIFO head (don't-care) because tx_valid=0.
- Each FIFO: circular buffer, rd_ptr/wr_ptr wrap modulo DEPTH, separate count[CW-1:0].
  - full = (count==DEPTH); empty = (count==0).
  - Simultaneous push and pop: both pointers advance, count unchanged. This holds at full and at empty only if the pop is legal.
- TX path:
  - tx_valid = !tx_empty; tx_data = head entry (combinational from storage).
  - Pop on tx_complete only. The head is therefore stable for the whole frame, as the UART requires, because it builds its shift message combinationally from tx_data.
  - After the pop the next head appears while the UART is still sending its stop bit. The UART starts it after the stop bit, giving back-to-back frames.
  - tx_complete while empty: ignored.
- RX path:
  - rx_complete with FIFO not full: push rx_data.
  - rx_complete with FIFO full: byte dropped, rx_overrun sticky flag set.
  - rx_complete coinciding with a CPU pop at full: push accepted, no overrun.
- CPU port:
  - cpu_ack asserted exactly 1 cycle after cpu_valid; cpu_rdata registered alongside it.
  - cpu_rdata = 0 when cpu_ack=0 or on a write.
  - cpu_valid is never issued back-to-back faster than the ack; no stalls.
  - Write DATA: push cpu_wdata to TX. If full, drop the byte and set tx_overflow sticky.
  - Read DATA: if RX non-empty, return {24'b0, head} and pop. If empty, return 32'hFFFFFFFF with no pop.
  - Read STATUS:
    - [0] rx_not_empty
    - [1] tx_full
    - [2] rx_overrun
    - [3] tx_overflow
    - [4] tx_idle (tx empty)
    - [15:8] rx_count (zero-extended)
    - [23:16] tx_count
    - others 0
  - Write STATUS: bits [2] and [3] are write-1-to-clear. If a set and a clear coincide in the same cycle, the set wins.
  - Read/write CTRL: [0] irq_enable (see optional feature); the remaining bits read 0. Without the feature, CTRL reads 0 and writes are ignored.
  - cpu_addr=3: reads 0, writes ignored, still acked.

Optional Feature:
- Macro: UART_RX_IRQ_EN.
- Defined: adds output port irq (1 bit, registered, reset 0), irq = CTRL[0] & (rx_not_empty | rx_overrun), updated each cycle.
- Undefined: no irq port, CTRL unimplemented.

Decomposition:
- Package uart_host_pkg holds:
  - register offsets ADDR_DATA=0, ADDR_STATUS=1, ADDR_CTRL=2;
  - STATUS bit indices;
  - empty-read constant 32'hFFFFFFFF.
- One sub-module, byte_fifo (parameter DEPTH): ports push, push_data, pop, head, full, empty, count. It is instantiated twice.

Test Plan:
- TX burst: write 0x41, 0x42, 0x43 to DATA; UART model pulses tx_complete 500 cycles after each start → tx_data sequence 41, 42, 43. tx_valid drops the cycle after the third tx_complete; STATUS[4]=1.
- RX overrun: 17 rx_complete pulses with data 0x00..0x10, no reads → STATUS[15:8]=16, STATUS[2]=1. Reads return 0x00..0x0F, then a 17th read returns 0xFFFFFFFF.
- TX full: 17 writes without tx_complete → STATUS[1]=1, STATUS[3]=1, tx_count=16. Write 0x08 to STATUS → bit3 clears, count unchanged.
- Simultaneous push/pop: RX FIFO full, CPU DATA read in the same cycle as rx_complete(0xAA) → no overrun, count stays 16, 0xAA is the last byte read.
- Reset mid-operation: 5 bytes queued in each FIFO, reset_n low for 1 cycle → tx_valid=0, counts 0, flags 0, next DATA read returns 0xFFFFFFFF.
- With UART_RX_IRQ_EN defined: CTRL=1 and one byte received → irq=1 the cycle after push. Reading it → irq=0 one cycle after the pop.
